term_loopback_switch_matrix: RTL and testbench

- Parametrised terminal-tile switch matrix for the fabric edge: every north-arriving wire group (single, double mid/end, quad, quad-hop) is looped back onto the matching south-departing group.
- Unlike the fixed MUX-1 terminal matrix, each group has a runtime-selectable routing mode and an optional output pipeline register.
- Configuration is loaded through a serial shadow chain with an atomic commit, so routing never glitches while bits are shifted in.

---
 rtl/term_loopback_switch_matrix_if.sv | 34 +++
 rtl/term_loopback_switch_matrix.sv | 107 ++++++++++
 tb/tb_term_loopback_switch_matrix.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/term_loopback_switch_matrix_if.sv
// Wire groups and serial configuration signals of the terminal loopback switch matrix.
// The master side drives the north wires and the config chain; the slave side is the matrix.
interface term_loopback_switch_matrix_if #(
  parameter int W1 = 4,
  parameter int W2 = 8,
  parameter int W4 = 16
);
  logic [W1-1:0] N1END;
  logic [W2-1:0] N2MID;
  logic [W2-1:0] N2END;
  logic [W4-1:0] NN4END;
  logic [W4-1:0] N4END;
  logic [W1-1:0] S1BEG;
  logic [W2-1:0] S2BEG;
  logic [W2-1:0] S2BEGb;
  logic [W4-1:0] SS4BEG;
  logic [W4-1:0] S4BEG;
  logic          cfg_en;
  logic          cfg_din;
  logic          cfg_dout;
  logic          cfg_commit;
  logic          cfg_full;
  logic          cfg_err;

  modport master (
    output N1END, N2MID, N2END, NN4END, N4END, cfg_en, cfg_din, cfg_commit,
    input  S1BEG, S2BEG, S2BEGb, SS4BEG, S4BEG, cfg_dout, cfg_full, cfg_err
  );

  modport slave (
    input  N1END, N2MID, N2END, NN4END, N4END, cfg_en, cfg_din, cfg_commit,
    output S1BEG, S2BEG, S2BEGb, SS4BEG, S4BEG, cfg_dout, cfg_full, cfg_err
  );
endinterface

// File: rtl/term_loopback_switch_matrix.sv
// Terminal-tile switch matrix: loops each north wire group back south with a per-group
// runtime mode and optional pipeline register, configured through a shadow chain.
module term_loopback_group #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic [1:0]   mode,
  input  logic         reg_en,
  output logic [W-1:0] dout
);
  logic [W-1:0] mapped;
  logic [W-1:0] pipe;

  always_comb begin
    mapped = '0;
    case (mode)
      2'b00: for (int i = 0; i < W; i++) mapped[i] = din[W-1-i];
      2'b01: mapped = din;
      2'b10: mapped = '0;
      2'b11: mapped = '1;
      default: mapped = '0;
    endcase
  end

  // Samples every cycle so flipping reg_en never exposes data older than one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pipe <= '0;
    else     pipe <= mapped;
  end

  assign dout = reg_en ? pipe : mapped;
endmodule

module term_loopback_switch_matrix #(
  parameter int W1       = 4,
  parameter int W2       = 8,
  parameter int W4       = 16,
  parameter int NGRP     = 5,
  parameter int CFG_BITS = 3 * NGRP
) (
  input logic UserCLK,
  input logic RST,
  term_loopback_switch_matrix_if.slave bus
);
  localparam int CW = $clog2(CFG_BITS + 1);

  logic [CFG_BITS-1:0] shadow;
  logic [CFG_BITS-1:0] active;
  logic [CW-1:0]       cnt;
  logic                err;
  logic                full;
  logic                commit_ok;

  assign full      = (cnt == CW'(CFG_BITS));
  assign commit_ok = bus.cfg_commit && full;

  // Active only moves on a successful commit, so shifting never disturbs routing.
  always_ff @(posedge UserCLK or posedge RST) begin
    if (RST) begin
      shadow <= '0;
      active <= '0;
      cnt    <= '0;
      err    <= 1'b0;
    end else begin
      if (bus.cfg_en) shadow <= {shadow[CFG_BITS-2:0], bus.cfg_din};
      if (commit_ok) begin
        active <= shadow;
        cnt    <= bus.cfg_en ? CW'(1) : CW'(0);
        err    <= 1'b0;
      end else begin
        if (bus.cfg_en && !full) cnt <= cnt + CW'(1);
        if (bus.cfg_commit)      err <= 1'b1;
      end
    end
  end

  assign bus.cfg_dout = shadow[CFG_BITS-1];
  assign bus.cfg_full = full;
  assign bus.cfg_err  = err;

  term_loopback_group #(.W(W1)) g_s1 (
    .clk(UserCLK), .rst(RST), .din(bus.N1END),
    .mode(active[1:0]), .reg_en(active[2]), .dout(bus.S1BEG)
  );

  term_loopback_group #(.W(W2)) g_s2 (
    .clk(UserCLK), .rst(RST), .din(bus.N2MID),
    .mode(active[4:3]), .reg_en(active[5]), .dout(bus.S2BEG)
  );

  term_loopback_group #(.W(W2)) g_s2b (
    .clk(UserCLK), .rst(RST), .din(bus.N2END),
    .mode(active[7:6]), .reg_en(active[8]), .dout(bus.S2BEGb)
  );

  term_loopback_group #(.W(W4)) g_ss4 (
    .clk(UserCLK), .rst(RST), .din(bus.NN4END),
    .mode(active[10:9]), .reg_en(active[11]), .dout(bus.SS4BEG)
  );

  term_loopback_group #(.W(W4)) g_s4 (
    .clk(UserCLK), .rst(RST), .din(bus.N4END),
    .mode(active[13:12]), .reg_en(active[14]), .dout(bus.S4BEG)
  );
endmodule

// File: tb/tb_term_loopback_switch_matrix.sv
// Self-checking bench: post-reset vector table, directed config sequences and randomized
// traffic compared against a queue-based reference model of the config chain and routing.
module tb_term_loopback_switch_matrix;
  localparam int CB = 15;

  logic UserCLK = 1'b0;
  logic RST;
  always #5 UserCLK = ~UserCLK;

  term_loopback_switch_matrix_if #(.W1(4), .W2(8), .W4(16)) bus ();

  term_loopback_switch_matrix dut (
    .UserCLK(UserCLK),
    .RST(RST),
    .bus(bus)
  );

  typedef struct {
    logic [3:0]  n1;
    logic [15:0] n4;
    logic [3:0]  s1;
    logic [15:0] s4;
  } vec_t;

  int          wid[5] = '{4, 8, 8, 16, 16};
  logic [15:0] in_val[5];
  logic [15:0] pipe_m[5];
  logic [1:0]  mode_m[5];
  logic        reg_m[5];
  bit          shq[$];
  int          cnt_m;
  logic        err_m;
  int          total = 0;
  int          passed = 0;

  function automatic logic [15:0] mask_of(int w);
    return (w == 16) ? 16'hFFFF : ((16'h1 << w) - 16'h1);
  endfunction

  function automatic logic [15:0] map_val(logic [15:0] v, logic [1:0] m, int w);
    logic [15:0] r = '0;
    case (m)
      2'b00: for (int i = 0; i < w; i++) if (v[i]) r[w-1-i] = 1'b1;
      2'b01: r = v & mask_of(w);
      2'b10: r = '0;
      default: r = mask_of(w);
    endcase
    return r;
  endfunction

  function automatic logic [15:0] dut_out(int g);
    case (g)
      0: return {12'h0, bus.S1BEG};
      1: return {8'h0, bus.S2BEG};
      2: return {8'h0, bus.S2BEGb};
      3: return bus.SS4BEG;
      default: return bus.S4BEG;
    endcase
  endfunction

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic model_reset();
    shq = {};
    for (int i = 0; i < CB; i++) shq.push_back(1'b0);
    cnt_m = 0;
    err_m = 1'b0;
    for (int g = 0; g < 5; g++) begin
      mode_m[g] = 2'b00;
      reg_m[g]  = 1'b0;
      pipe_m[g] = '0;
    end
  endtask

  task automatic drive_inputs();
    bus.N1END  = in_val[0][3:0];
    bus.N2MID  = in_val[1][7:0];
    bus.N2END  = in_val[2][7:0];
    bus.NN4END = in_val[3];
    bus.N4END  = in_val[4];
  endtask

  task automatic set_inputs(logic [3:0] n1, logic [7:0] n2m, logic [7:0] n2e,
                            logic [15:0] nn4, logic [15:0] n4);
    in_val[0] = {12'h0, n1};
    in_val[1] = {8'h0, n2m};
    in_val[2] = {8'h0, n2e};
    in_val[3] = nn4;
    in_val[4] = n4;
    drive_inputs();
    #1;
  endtask

  task automatic applyStimulus(logic en, logic din, logic commit);
    bit ok;
    bus.cfg_en     = en;
    bus.cfg_din    = din;
    bus.cfg_commit = commit;
    for (int g = 0; g < 5; g++) pipe_m[g] = map_val(in_val[g], mode_m[g], wid[g]);
    ok = commit && (cnt_m == CB);
    if (ok) begin
      for (int g = 0; g < 5; g++) begin
        mode_m[g] = {shq[CB-1-(3*g+1)], shq[CB-1-3*g]};
        reg_m[g]  = shq[CB-1-(3*g+2)];
      end
      err_m = 1'b0;
    end else if (commit) begin
      err_m = 1'b1;
    end
    if (en) begin
      shq.push_back(din);
      if (shq.size() > CB) void'(shq.pop_front());
    end
    if (ok) cnt_m = en ? 1 : 0;
    else if (en && cnt_m < CB) cnt_m++;
    @(posedge UserCLK);
    #1;
    bus.cfg_en     = 1'b0;
    bus.cfg_din    = 1'b0;
    bus.cfg_commit = 1'b0;
  endtask

  task automatic checkOutput(string tag);
    for (int g = 0; g < 5; g++)
      chk($sformatf("%s grp%0d", tag, g), dut_out(g),
          reg_m[g] ? pipe_m[g] : map_val(in_val[g], mode_m[g], wid[g]));
    chk({tag, " cfg_full"}, {15'h0, bus.cfg_full}, {15'h0, cnt_m == CB});
    chk({tag, " cfg_err"},  {15'h0, bus.cfg_err},  {15'h0, err_m});
    chk({tag, " cfg_dout"}, {15'h0, bus.cfg_dout}, {15'h0, shq[0]});
  endtask

  task automatic shift_bits(logic [14:0] c, int hi, int lo);
    for (int i = hi; i >= lo; i--) applyStimulus(1'b1, c[i], 1'b0);
  endtask

  task automatic commit();
    applyStimulus(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    vec_t vecs[6];
    vecs[0] = '{n1: 4'b0001, n4: 16'h0001, s1: 4'b1000, s4: 16'h8000};
    vecs[1] = '{n1: 4'b0011, n4: 16'h1234, s1: 4'b1100, s4: 16'h2C48};
    vecs[2] = '{n1: 4'b1110, n4: 16'hF000, s1: 4'b0111, s4: 16'h000F};
    vecs[3] = '{n1: 4'b0000, n4: 16'h0000, s1: 4'b0000, s4: 16'h0000};
    vecs[4] = '{n1: 4'b1111, n4: 16'hFFFF, s1: 4'b1111, s4: 16'hFFFF};
    vecs[5] = '{n1: 4'b1010, n4: 16'hA5C3, s1: 4'b0101, s4: 16'hC3A5};

    RST = 1'b1;
    bus.cfg_en = 1'b0;
    bus.cfg_din = 1'b0;
    bus.cfg_commit = 1'b0;
    model_reset();
    set_inputs(4'h0, 8'h00, 8'h00, 16'h0000, 16'h0000);
    #12 RST = 1'b0;
    @(posedge UserCLK);
    #1;

    for (int i = 0; i < 6; i++) begin
      set_inputs(vecs[i].n1, 8'h00, 8'h00, 16'h0000, vecs[i].n4);
      chk($sformatf("vec%0d S1BEG", i), {12'h0, bus.S1BEG}, {12'h0, vecs[i].s1});
      chk($sformatf("vec%0d S4BEG", i), bus.S4BEG, vecs[i].s4);
    end
    chk("reset cfg_full", {15'h0, bus.cfg_full}, 16'h0);
    chk("reset cfg_err",  {15'h0, bus.cfg_err},  16'h0);
    checkOutput("reset");

    shift_bits(15'h0001, 14, 0);
    chk("straight full before commit", {15'h0, bus.cfg_full}, 16'h1);
    commit();
    chk("straight full after commit", {15'h0, bus.cfg_full}, 16'h0);
    set_inputs(4'b0011, 8'h01, 8'h80, 16'h0001, 16'h0002);
    chk("straight S1BEG", {12'h0, bus.S1BEG}, 16'h0003);
    chk("straight S2BEG reversed", {8'h0, bus.S2BEG}, 16'h0080);
    checkOutput("straight");

    shift_bits(15'h0C00, 14, 0);
    commit();
    applyStimulus(1'b0, 1'b0, 1'b0);
    chk("ss4 reg tie-low", bus.SS4BEG, 16'h0000);
    checkOutput("ss4 tie-low");
    shift_bits(15'h0800, 14, 0);
    commit();
    set_inputs(4'b0011, 8'h01, 8'h80, 16'h1234, 16'h0002);
    checkOutput("ss4 pre-latency");
    applyStimulus(1'b0, 1'b0, 1'b0);
    chk("ss4 reg reverse", bus.SS4BEG, 16'h2C48);
    checkOutput("ss4 reverse");

    shift_bits(15'h2008, 14, 8);
    commit();
    chk("partial cfg_err", {15'h0, bus.cfg_err}, 16'h1);
    checkOutput("partial commit");
    shift_bits(15'h2008, 7, 0);
    commit();
    set_inputs(4'b0110, 8'h5A, 8'h3C, 16'h00FF, 16'hBEEF);
    chk("completed cfg_err", {15'h0, bus.cfg_err}, 16'h0);
    chk("completed S2BEG", {8'h0, bus.S2BEG}, 16'h005A);
    chk("completed S4BEG", bus.S4BEG, 16'h0000);
    checkOutput("completed");

    shift_bits(15'h4000, 14, 0);
    chk("pre-overlap dout", {15'h0, bus.cfg_dout}, 16'h1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    chk("overlap cfg_full", {15'h0, bus.cfg_full}, 16'h0);
    chk("overlap cfg_dout", {15'h0, bus.cfg_dout}, 16'h0);
    checkOutput("overlap");
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("overlap+1");

    shift_bits(15'h7000, 14, 0);
    commit();
    applyStimulus(1'b0, 1'b0, 1'b0);
    chk("s4 reg tie-high", bus.S4BEG, 16'hFFFF);
    shift_bits(15'h7FFF, 14, 6);
    #2 RST = 1'b1;
    model_reset();
    #1;
    chk("rst S4BEG reversed", bus.S4BEG, 16'hF77D);
    chk("rst cfg_dout", {15'h0, bus.cfg_dout}, 16'h0);
    checkOutput("mid-shift reset");
    #2 RST = 1'b0;
    shift_bits(15'h7FFF, 14, 9);
    chk("post-rst 6 shifts not full", {15'h0, bus.cfg_full}, 16'h0);
    shift_bits(15'h7FFF, 8, 0);
    chk("post-rst 15 shifts full", {15'h0, bus.cfg_full}, 16'h1);

    for (int n = 0; n < 400; n++) begin
      for (int g = 0; g < 5; g++) in_val[g] = 16'($urandom) & mask_of(wid[g]);
      drive_inputs();
      #1;
      checkOutput($sformatf("rand%0d", n));
      applyStimulus(($urandom_range(0, 9) < 7), 1'($urandom), ($urandom_range(0, 9) == 0));
    end

    $display("[TB] %0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
